// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with deferred-jump handling and event counters
module pipe_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        jump_enable,
  output logic [5:0]  stall_out,
  output logic        flush_out,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_HOLD = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        pending_flush, pending_nxt;
  logic        id_eff;
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 16'd0;
    end else if (rdy_in) begin
      state         <= state_nxt;
      pending_flush <= pending_nxt;
      if (stall_out != 6'b000000) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_out) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_flush;
    flush_out   = 1'b0;
    stall_out   = 6'b000000;

    // ID already holds a squashed bubble during FLUSH, so a load-use stall there is stale
    id_eff = id_stall_req && (state != FLUSH);

    if (mem_stall_req)     stall_out = 6'b011111;
    else if (id_eff)       stall_out = 6'b000111;
    else if (if_stall_req) stall_out = 6'b000011;

    case (state)
      RUN: begin
        if (mem_stall_req) begin
          state_nxt   = MEM_HOLD;
          pending_nxt = jump_enable;
        end else if (jump_enable) begin
          flush_out = 1'b1;
          state_nxt = FLUSH;
        end
      end
      MEM_HOLD: begin
        // EX is frozen: remember the jump and flush once memory releases
        if (mem_stall_req) begin
          pending_nxt = pending_flush | jump_enable;
        end else begin
          flush_out   = pending_flush | jump_enable;
          pending_nxt = 1'b0;
          state_nxt   = (pending_flush | jump_enable) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (mem_stall_req) begin
          state_nxt   = MEM_HOLD;
          pending_nxt = jump_enable;
        end else if (jump_enable) begin
          flush_out = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt   = RUN;
        pending_nxt = 1'b0;
      end
    endcase

    if (rst_in) begin
      stall_out = 6'b000000;
      flush_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_stall_req = 1'b0;
  logic        id_stall_req = 1'b0;
  logic        mem_stall_req = 1'b0;
  logic        jump_enable = 1'b0;
  logic [5:0]  stall_out;
  logic        flush_out;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  pipe_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .if_stall_req  (if_stall_req),
    .id_stall_req  (id_stall_req),
    .mem_stall_req (mem_stall_req),
    .jump_enable   (jump_enable),
    .stall_out     (stall_out),
    .flush_out     (flush_out),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 = RUN, 1 = MEM_HOLD, 2 = FLUSH
  int          m_state = 0;
  logic        m_pend  = 1'b0;
  logic [31:0] m_sc    = 32'd0;
  logic [15:0] m_fc    = 16'd0;

  logic [6:0]  comb_q[$];
  logic [47:0] cnt_q[$];

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    if_stall_req = 1'b1;
    id_stall_req = 1'b1;
    mem_stall_req = 1'b1;
    jump_enable = 1'b1;
    #1;
    check_eq("rst_stall_out", {42'd0, stall_out}, 48'd0);
    check_eq("rst_flush_out", {47'd0, flush_out}, 48'd0);
    check_eq("rst_counters", {stall_cycles, flush_count}, 48'd0);
    m_state = 0; m_pend = 1'b0; m_sc = 32'd0; m_fc = 16'd0;
    @(negedge clk_in);
    rst_in = 1'b0;
    if_stall_req = 1'b0;
    id_stall_req = 1'b0;
    mem_stall_req = 1'b0;
    jump_enable = 1'b0;
  endtask

  // one cycle: drive at negedge, check combinational outputs, then counters after the edge
  task automatic drive(input logic r, input logic ifs, input logic ids, input logic mems, input logic jmp);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        id_m;
    logic [6:0]  ce;
    logic [47:0] ke;
    rdy_in = r; if_stall_req = ifs; id_stall_req = ids; mem_stall_req = mems; jump_enable = jmp;

    id_m    = ids && (m_state != 2);
    e_stall = mems ? 6'h1F : id_m ? 6'h07 : ifs ? 6'h03 : 6'h00;
    e_flush = !mems && (jmp || (m_state == 1 && m_pend));
    comb_q.push_back({e_stall, e_flush});
    if (r) begin
      if (e_stall != 0) m_sc = m_sc + 1;
      if (e_flush) m_fc = m_fc + 1;
      if (mems) begin
        m_pend  = (m_state == 1) ? (m_pend | jmp) : jmp;
        m_state = 1;
      end else begin
        m_pend  = 1'b0;
        m_state = e_flush ? 2 : 0;
      end
    end
    cnt_q.push_back({m_sc, m_fc});

    #1;
    ce = comb_q.pop_front();
    check_eq("stall_out", {42'd0, stall_out}, {42'd0, ce[6:1]});
    check_eq("flush_out", {47'd0, flush_out}, {47'd0, ce[0]});
    @(posedge clk_in);
    #1;
    ke = cnt_q.pop_front();
    check_eq("stall_cycles", {16'd0, stall_cycles}, {16'd0, ke[47:16]});
    check_eq("flush_count", {32'd0, flush_count}, {32'd0, ke[15:0]});
    @(negedge clk_in);
  endtask

  initial begin
    @(negedge clk_in);
    do_reset();

    // idle then three fetch stalls
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      check_eq("if_stall_bus", {42'd0, stall_out}, 48'h3);
    end
    check_eq("if_stall_count", {16'd0, stall_cycles}, 48'd3);
    drive(1, 0, 0, 0, 0);

    // mem beats id, then id alone
    do_reset();
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 1, 0, 0);
    check_eq("id_after_mem", {42'd0, stall_out}, 48'h07);

    // jump in RUN, then masked id stall in FLUSH, then id honoured again
    do_reset();
    drive(1, 0, 0, 0, 1);
    check_eq("jump_flush_count", {32'd0, flush_count}, 48'd1);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);

    // back-to-back jumps keep FLUSH
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0);

    // jump deferred across 4 mem cycles: exactly one pulse
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_eq("deferred_flush_count", {32'd0, flush_count}, 48'd1);

    // reset mid-MEM_HOLD discards the pending jump
    do_reset();
    drive(1, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 0);
    do_reset();
    drive(1, 0, 0, 0, 0);
    check_eq("post_rst_flush", {47'd0, flush_out}, 48'd0);
    check_eq("post_rst_counts", {stall_cycles, flush_count}, 48'd0);

    // rdy low: outputs still driven, state and counters frozen
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // counter wrap and freeze at all-ones
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFF;
    drive(0, 0, 0, 1, 0);
    check_eq("wrap_hold", {16'd0, stall_cycles}, 48'hFFFF_FFFF);
    drive(1, 0, 0, 1, 0);
    check_eq("wrap_zero", {16'd0, stall_cycles}, 48'd0);
    drive(1, 0, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
